set_scan_ctrl: RTL and testbench
================================

# set_scan_ctrl

Scan controller for the circle-set candidate counter. On a start request it latches one configuration: three circle centres, three squared radii and a set-combination mode. It drives that configuration to the combinational subset evaluator and then sweeps every grid position through it, one position per cycle. It counts the positions the evaluator reports as activated and returns the count with a one-cycle valid pulse. The block sits between the top-level command interface and the evaluator; it contains no distance arithmetic itself.

## Interface
Parameters:
- GRID_N, 8: grid edge length; coordinates run 1..GRID_N on each axis; legal 1..15.
- CNT_W, 7: candidate counter width; must hold GRID_N*GRID_N.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  start request; accepted only in a cycle where busy=0.
- central  in  24  {xA,yA,xB,yB,xC,yC}, 4 bits each; sampled on the accepted en.
- radius_square  in  24  {rA²,rB²,rC²}, 8 bits each; sampled on the accepted en.
- mode  in  2  set-combination select; sampled on the accepted en.
- cfg_central  out  24  registered copy of central, to the evaluator.
- cfg_radius_square  out  24  registered copy of radius_square, to the evaluator.
- cfg_mode  out  2  registered copy of mode, to the evaluator.
- position  out  8  {x[3:0], y[3:0]} presented to the evaluator.
- activated  in  1  evaluator result for the current position; combinational, same cycle.
- busy  out  1  high while a scan is in progress.
- valid  out  1  one-cycle pulse; candidate is final.
- candidate  out  CNT_W  number of activated positions in the last completed scan.

## Operation
- State machine: IDLE, SCAN, DONE.
- IDLE, en=1:
  - Latch central, radius_square and mode into the cfg_* registers.
  - Load position=8'h11 and clear the count.
  - Go to SCAN.
- IDLE, en=0: hold all state.
- SCAN, each cycle:
  - count <= count + activated.
  - Advance position with x as the inner loop: (1,1),(2,1)…(N,1),(1,2)…(N,N).
  - When x=N, x wraps to 1 and y increments.
- SCAN at (N,N):
  - candidate <= count + activated.
  - position holds at (N,N).
  - Go to DONE.
- DONE, lasts exactly one cycle:
  - valid=1.
  - en=1 is accepted exactly as in IDLE and goes to SCAN.
  - Otherwise go to IDLE.
- en while busy=1 is ignored. It is not queued.
- cfg_* registers change only on an accepted en. Changes on central, radius_square or mode during a scan have no effect.
- activated is ignored outside SCAN. X or Z on it in IDLE or DONE must not corrupt state.
- Count width: CNT_W bits, no saturation needed. Maximum value is GRID_N², which is 64 at the default.
- candidate holds its value until the next scan completes.

## Timing
- Reset values, applied on the next edge with rst_n=0:
  - state=IDLE, busy=0, valid=0, candidate=0.
  - position=8'h00, cfg_*=0, internal count=0.
- Reset mid-scan: the scan is aborted at that edge. No valid pulse is produced and candidate=0.
- busy is registered and high exactly in SCAN.
- en accepted at edge T:
  - busy=1 and position=(1,1) from T+1.
  - SCAN occupies cycles T+1 .. T+GRID_N².
  - valid=1 and candidate is updated in cycle T+GRID_N²+1, i.e. T+65 at the default.
  - busy=0 in that same cycle.
- Back-to-back: en in the DONE cycle D gives busy=1 at D+1. There is no idle gap.
- Evaluator path: cfg_* and position are launched from registers, and activated is sampled at the end of the same cycle. The evaluator is therefore a single-cycle combinational path.

## Test plan
- Reset:
  - Assert rst_n=0 for 2 cycles with random inputs.
  - Required: busy=0, valid=0, candidate=0, position=8'h00, cfg_*=0.
  - Then en=0 for 10 cycles. Required: outputs unchanged.
- Geometry scan:
  - en with central=24'h44_0000, radius_square=24'h04_0000, mode=0.
  - Bench model drives activated = ((x-4)²+(y-4)² ≤ 4).
  - Required: busy high for 64 cycles, then valid for 1 cycle with candidate=13.
  - cfg_central=24'h440000 throughout the scan.
- Count boundaries:
  - activated tied to 1 -> candidate=64.
  - activated tied to 0 -> candidate=0.
  - activated = (x==y) -> candidate=8.
  - Position sequence checked against (1,1),(2,1)…(8,8), one per cycle.
- Start handling:
  - en pulsed at cycle 5 and cycle 20 of a scan -> ignored; exactly one valid, 65 cycles after the accepted en.
  - en held during the DONE cycle -> second scan starts at the next cycle, with a second valid 65 cycles later.
  - mode and central changed at cycle 10 of a scan -> cfg_* outputs unchanged until the next accepted en.
- Reset mid-scan:
  - rst_n=0 at cycle 30 of a scan that would give candidate=64.
  - Required: busy=0 and candidate=0 the next cycle; no valid pulse ever appears for that scan.
  - A fresh en then completes normally with candidate=64.

Source files
------------

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: latches one circle-set configuration and sweeps the grid through the evaluator, counting activated positions.
module set_scan_ctrl #(
    parameter int GRID_N = 8,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [23:0]      central,
    input  logic [23:0]      radius_square,
    input  logic [1:0]       mode,
    output logic [23:0]      cfg_central,
    output logic [23:0]      cfg_radius_square,
    output logic [1:0]       cfg_mode,
    output logic [7:0]       position,
    input  logic             activated,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] candidate
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [3:0] N = 4'(GRID_N);
    state_t           r_state;
    logic [23:0]      r_central;
    logic [23:0]      r_radius_square;
    logic [1:0]       r_mode;
    logic [3:0]       r_x;
    logic [3:0]       r_y;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_candidate;
    logic             r_busy;
    logic             r_valid;
    logic             w_start;
    logic             w_last;
    logic [CNT_W-1:0] w_next_count;
    assign w_start      = en && (r_state != SCAN);
    assign w_last       = (r_x == N) && (r_y == N);
    assign w_next_count = r_count + CNT_W'(activated);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_central       <= '0;
            r_radius_square <= '0;
            r_mode          <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_count         <= '0;
            r_candidate     <= '0;
            r_busy          <= 1'b0;
            r_valid         <= 1'b0;
        end else if (r_state == SCAN) begin
            // activated is only consumed here, so X outside SCAN never reaches state
            r_count <= w_next_count;
            if (w_last) begin
                r_candidate <= w_next_count;
                r_state     <= DONE;
                r_busy      <= 1'b0;
                r_valid     <= 1'b1;
            end else begin
                r_x <= (r_x == N) ? 4'd1 : r_x + 4'd1;
                r_y <= (r_x == N) ? r_y + 4'd1 : r_y;
            end
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_central       <= central;
                r_radius_square <= radius_square;
                r_mode          <= mode;
                r_x             <= 4'd1;
                r_y             <= 4'd1;
                r_count         <= '0;
                r_busy          <= 1'b1;
                r_state         <= SCAN;
            end else begin
                r_state <= IDLE;
            end
        end
    end
    assign cfg_central       = r_central;
    assign cfg_radius_square = r_radius_square;
    assign cfg_mode          = r_mode;
    assign position          = {r_x, r_y};
    assign busy              = r_busy;
    assign valid             = r_valid;
    assign candidate         = r_candidate;
endmodule

// File: tb/tb_set_scan_ctrl.sv
// tb_set_scan_ctrl: directed scans with a behavioural evaluator and a queue of expected candidate counts.
module tb_set_scan_ctrl;
    localparam int GRID_N = 8;
    localparam int CNT_W  = 7;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [23:0]      central = '0;
    logic [23:0]      radius_square = '0;
    logic [1:0]       mode = '0;
    logic [23:0]      cfg_central;
    logic [23:0]      cfg_radius_square;
    logic [1:0]       cfg_mode;
    logic [7:0]       position;
    logic             activated;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] candidate;
    int               sel = 0;
    int               checks = 0;
    int               errors = 0;
    int               exp_q[$];
    logic [23:0]      lat_c = '0;
    logic [23:0]      lat_r = '0;
    logic [1:0]       lat_m = '0;
    logic [CNT_W-1:0] last_cand = '0;

    set_scan_ctrl #(.GRID_N(GRID_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .central(central),
        .radius_square(radius_square), .mode(mode),
        .cfg_central(cfg_central), .cfg_radius_square(cfg_radius_square),
        .cfg_mode(cfg_mode), .position(position), .activated(activated),
        .busy(busy), .valid(valid), .candidate(candidate)
    );

    always #5 clk = ~clk;

    function automatic logic eval(int s, int x, int y);
        return (s == 0) ? ((x-4)*(x-4) + (y-4)*(y-4) <= 4) :
               (s == 1) ? 1'b1 : (s == 2) ? 1'b0 : (x == y);
    endfunction

    // Evaluator stand-in; drives X whenever no scan is running
    always_comb begin
        activated = 1'bx;
        if (busy) activated = eval(sel, int'(position[7:4]), int'(position[3:0]));
    end

    function automatic int model(int s);
        int n = 0;
        for (int y = 1; y <= GRID_N; y++)
            for (int x = 1; x <= GRID_N; x++)
                n += int'(eval(s, x, y));
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [23:0] c, input logic [23:0] r, input logic [1:0] m, input int s);
        central = c; radius_square = r; mode = m; sel = s; en = 1'b1;
        lat_c = c; lat_r = r; lat_m = m;
        exp_q.push_back(model(s));
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic run_scan(input bit disturb);
        int e;
        for (int i = 0; i < GRID_N*GRID_N; i++) begin
            chk("busy_scan", 32'(busy), 32'd1);
            chk("valid_scan", 32'(valid), 32'd0);
            chk("position", 32'(position), 32'({4'(i % GRID_N + 1), 4'(i / GRID_N + 1)}));
            chk("cfg_central", 32'(cfg_central), 32'(lat_c));
            chk("cfg_radius", 32'(cfg_radius_square), 32'(lat_r));
            chk("cfg_mode", 32'(cfg_mode), 32'(lat_m));
            if (disturb) begin
                en = (i == 4 || i == 19);
                if (i == 9) begin
                    central = $urandom; radius_square = $urandom; mode = ~mode;
                end
            end
            @(negedge clk);
        end
        en = 1'b0;
        e = exp_q.pop_front();
        chk("valid_done", 32'(valid), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("candidate", 32'(candidate), 32'(e));
        last_cand = CNT_W'(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_cand"}, 32'(candidate), 32'(last_cand));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom); central = $urandom; radius_square = $urandom; mode = 2'($urandom);
            @(negedge clk);
        end
        en = 1'b0;
        chk_idle("reset");
        chk("reset_pos", 32'(position), 32'h00);
        chk("reset_cfg_c", 32'(cfg_central), 32'd0);
        chk("reset_cfg_r", 32'(cfg_radius_square), 32'd0);
        chk("reset_cfg_m", 32'(cfg_mode), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle("idle");
            chk("idle_pos", 32'(position), 32'h00);
            chk("idle_cfg_c", 32'(cfg_central), 32'd0);
        end
        start(24'h44_0000, 24'h04_0000, 2'd0, 0);
        run_scan(1'b0);
        @(negedge clk);
        chk_idle("after_geom");
        start(24'h12_3456, 24'h01_0203, 2'd2, 1);
        run_scan(1'b1);
        @(negedge clk);
        chk_idle("after_disturb");
        start(24'h55_5555, 24'h09_0909, 2'd1, 3);
        run_scan(1'b0);
        start(24'hAB_CDEF, 24'hFF_0000, 2'd3, 2);
        run_scan(1'b0);
        @(negedge clk);
        chk_idle("after_b2b");
        start(24'h11_1111, 24'h10_1010, 2'd1, 1);
        for (int i = 0; i < 29; i++) begin
            chk("pre_rst_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        void'(exp_q.pop_front());
        last_cand = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("mid_rst");
        chk("mid_rst_cfg", 32'(cfg_central), 32'd0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            chk("no_valid", 32'(valid), 32'd0);
        end
        start(24'h33_3333, 24'h20_2020, 2'd0, 1);
        run_scan(1'b0);
        @(negedge clk);
        chk_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
